// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives
//   the stall/clear controls of the fetch, issue and execute pipeline
//   registers. It resolves load-use interlocks, branch-mispredict flushes and
//   multi-cycle mul/div occupancy, and it produces the EX operand forwarding
//   selects.
//
//   Optional build macro HAZ_PERF_CNT_EN adds the stall_cnt_o/flush_cnt_o
//   performance counters.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   valid_id_i, rs_id_i, rt_id_i issue-stage instruction and sources
//   valid_ex_i, mem_to_reg_ex_i, reg_wr_ex_i, dst_ex_i, rs_ex_i, rt_ex_i
//                                EX-stage instruction info
//   reg_wr_mem_i, dst_mem_i      MEM-stage writeback info
//   reg_wr_wb_i, dst_wb_i        WB-stage writeback info
//   mispredict_ex_i              branch/jump mispredict resolved in EX
//   md_start_ex_i, md_is_div_ex_i  mul/div launch and type
//   stall_if_o, stall_id_o       hold fetch / issue registers
//   clr_id_o, clr_ex_o           clear issue / issue-execute registers
//   fwd_a_sel_o, fwd_b_sel_o     00 regfile, 01 WB, 10 MEM
//   md_busy_o, md_done_o         mul/div occupancy and final-cycle pulse
//   stall_cnt_o, flush_cnt_o     perf counters (HAZ_PERF_CNT_EN only)

module pipe_hazard_ctrl #(
  parameter int MUL_LAT      = 4,
  parameter int DIV_LAT      = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_id_i,
  input  logic [4:0] rs_id_i,
  input  logic [4:0] rt_id_i,
  input  logic       valid_ex_i,
  input  logic       mem_to_reg_ex_i,
  input  logic       reg_wr_ex_i,
  input  logic [4:0] dst_ex_i,
  input  logic [4:0] rs_ex_i,
  input  logic [4:0] rt_ex_i,
  input  logic       reg_wr_mem_i,
  input  logic [4:0] dst_mem_i,
  input  logic       reg_wr_wb_i,
  input  logic [4:0] dst_wb_i,
  input  logic       mispredict_ex_i,
  input  logic       md_start_ex_i,
  input  logic       md_is_div_ex_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       clr_id_o,
  output logic       clr_ex_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o,
  output logic       md_busy_o,
  output logic       md_done_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, MD_BUSY, FLUSH} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   md_cnt, md_cnt_n;
  logic [1:0]      flush_cnt, flush_cnt_n;
  logic            lu;
  logic            fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb;

  assign lu = valid_id_i & valid_ex_i & mem_to_reg_ex_i & reg_wr_ex_i &
              (dst_ex_i != 5'd0) & ((dst_ex_i == rs_id_i) | (dst_ex_i == rt_id_i));

  assign fwd_a_mem = reg_wr_mem_i & (dst_mem_i != 5'd0) & (dst_mem_i == rs_ex_i);
  assign fwd_a_wb  = reg_wr_wb_i  & (dst_wb_i  != 5'd0) & (dst_wb_i  == rs_ex_i);
  assign fwd_b_mem = reg_wr_mem_i & (dst_mem_i != 5'd0) & (dst_mem_i == rt_ex_i);
  assign fwd_b_wb  = reg_wr_wb_i  & (dst_wb_i  != 5'd0) & (dst_wb_i  == rt_ex_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      md_cnt    <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      md_cnt    <= md_cnt_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    md_cnt_n    = md_cnt;
    flush_cnt_n = flush_cnt;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    clr_id_o    = 1'b0;
    clr_ex_o    = 1'b0;
    md_done_o   = 1'b0;
    md_busy_o   = (state == MD_BUSY);
    fwd_a_sel_o = fwd_a_mem ? 2'b10 : (fwd_a_wb ? 2'b01 : 2'b00);
    fwd_b_sel_o = fwd_b_mem ? 2'b10 : (fwd_b_wb ? 2'b01 : 2'b00);

    if (mispredict_ex_i) begin
      // Overrides every state: kills any mul/div in flight without a done pulse.
      clr_id_o = 1'b1;
      clr_ex_o = 1'b1;
      md_cnt_n = '0;
      if (FLUSH_CYCLES > 1) begin
        state_n     = FLUSH;
        flush_cnt_n = 2'(FLUSH_CYCLES - 1);
      end else begin
        state_n     = IDLE;
        flush_cnt_n = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // mul/div start outranks load-use; lu is seen again once the unit frees up.
          if (md_start_ex_i) begin
            state_n  = MD_BUSY;
            md_cnt_n = md_is_div_ex_i ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          end else if (lu) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            clr_ex_o   = 1'b1;
          end
        end
        MD_BUSY: begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          md_cnt_n   = md_cnt - CW'(1);
          if (md_cnt == CW'(1)) begin
            md_done_o = 1'b1;
            state_n   = IDLE;
            md_cnt_n  = '0;
          end
        end
        FLUSH: begin
          clr_id_o    = (flush_cnt != 2'd0);
          clr_ex_o    = (flush_cnt != 2'd0);
          flush_cnt_n = flush_cnt - 2'd1;
          if (flush_cnt <= 2'd1) begin
            state_n     = IDLE;
            flush_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Outputs are forced low for the whole time reset is held.
    if (!reset_n) begin
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      clr_id_o    = 1'b0;
      clr_ex_o    = 1'b0;
      md_done_o   = 1'b0;
      md_busy_o   = 1'b0;
      fwd_a_sel_o = 2'b00;
      fwd_b_sel_o = 2'b00;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_if_o)      stall_cnt_o <= stall_cnt_o + 32'd1;
      if (mispredict_ex_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MUL_LAT=4, DIV_LAT=32, FLUSH_CYCLES=3).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_id_i, valid_ex_i, mem_to_reg_ex_i, reg_wr_ex_i;
  logic [4:0] rs_id_i, rt_id_i, dst_ex_i, rs_ex_i, rt_ex_i, dst_mem_i, dst_wb_i;
  logic       reg_wr_mem_i, reg_wr_wb_i, mispredict_ex_i, md_start_ex_i, md_is_div_ex_i;
  logic       stall_if_o, stall_id_o, clr_id_o, clr_ex_o, md_busy_o, md_done_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_id_i(valid_id_i), .rs_id_i(rs_id_i), .rt_id_i(rt_id_i),
    .valid_ex_i(valid_ex_i), .mem_to_reg_ex_i(mem_to_reg_ex_i),
    .reg_wr_ex_i(reg_wr_ex_i), .dst_ex_i(dst_ex_i),
    .rs_ex_i(rs_ex_i), .rt_ex_i(rt_ex_i),
    .reg_wr_mem_i(reg_wr_mem_i), .dst_mem_i(dst_mem_i),
    .reg_wr_wb_i(reg_wr_wb_i), .dst_wb_i(dst_wb_i),
    .mispredict_ex_i(mispredict_ex_i), .md_start_ex_i(md_start_ex_i),
    .md_is_div_ex_i(md_is_div_ex_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
    .clr_id_o(clr_id_o), .clr_ex_o(clr_ex_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
    .md_busy_o(md_busy_o), .md_done_o(md_done_o)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_id_i = 0; rs_id_i = 0; rt_id_i = 0;
    valid_ex_i = 0; mem_to_reg_ex_i = 0; reg_wr_ex_i = 0; dst_ex_i = 0;
    rs_ex_i = 0; rt_ex_i = 0;
    reg_wr_mem_i = 0; dst_mem_i = 0; reg_wr_wb_i = 0; dst_wb_i = 0;
    mispredict_ex_i = 0; md_start_ex_i = 0; md_is_div_ex_i = 0;
  endtask

  // Load in EX writing $5, consumer in ID reading $5 via rs.
  task automatic drive_load_use();
    valid_id_i = 1; rs_id_i = 5; rt_id_i = 9;
    valid_ex_i = 1; mem_to_reg_ex_i = 1; reg_wr_ex_i = 1; dst_ex_i = 5;
  endtask

  task automatic test_reset();
    logic [9:0] all_out;
    reset_n = 0;
    clear_inputs();
    #3;
    all_out = {stall_if_o, stall_id_o, clr_id_o, clr_ex_o, fwd_a_sel_o, fwd_b_sel_o, md_busy_o, md_done_o};
    checks++;
    if (all_out !== 10'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", all_out, 10'b0);
    end
    step();
    reset_n = 1;
    step();
  endtask

  task automatic test_load_use();
    logic [3:0] o;
    drive_load_use();
    #2; o = {stall_if_o, stall_id_o, clr_ex_o, clr_id_o};
    checks++;
    if (o !== 4'b1110) begin errors++; $display("FAIL lu_rs got %b exp %b", o, 4'b1110); end
    step();
    valid_ex_i = 0;  // bubble now sits in EX
    #2; o = {stall_if_o, stall_id_o, clr_ex_o, clr_id_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL lu_one_cycle got %b exp %b", o, 4'b0000); end
    step();
    drive_load_use(); rs_id_i = 3; rt_id_i = 5;
    #2; o = {stall_if_o, stall_id_o, clr_ex_o, clr_id_o};
    checks++;
    if (o !== 4'b1110) begin errors++; $display("FAIL lu_rt got %b exp %b", o, 4'b1110); end
    step();
    drive_load_use(); dst_ex_i = 0; rs_id_i = 0; rt_id_i = 0;
    #2; o = {stall_if_o, stall_id_o, clr_ex_o, clr_id_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL lu_reg0 got %b exp %b", o, 4'b0000); end
    step();
    drive_load_use(); mem_to_reg_ex_i = 0;
    #2; o = {stall_if_o, stall_id_o, clr_ex_o, clr_id_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL lu_not_load got %b exp %b", o, 4'b0000); end
    step();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    logic [3:0] f;
    reg_wr_mem_i = 1; dst_mem_i = 7; reg_wr_wb_i = 1; dst_wb_i = 7;
    rs_ex_i = 7; rt_ex_i = 7;
    #2; f = {fwd_a_sel_o, fwd_b_sel_o};
    checks++;
    if (f !== 4'b1010) begin errors++; $display("FAIL fwd_mem_prio got %b exp %b", f, 4'b1010); end
    reg_wr_mem_i = 0;
    #2; f = {fwd_a_sel_o, fwd_b_sel_o};
    checks++;
    if (f !== 4'b0101) begin errors++; $display("FAIL fwd_wb got %b exp %b", f, 4'b0101); end
    rs_ex_i = 0;
    #2; f = {fwd_a_sel_o, fwd_b_sel_o};
    checks++;
    if (f !== 4'b0001) begin errors++; $display("FAIL fwd_rs0 got %b exp %b", f, 4'b0001); end
    dst_wb_i = 0; rs_ex_i = 0; rt_ex_i = 0;
    #2; f = {fwd_a_sel_o, fwd_b_sel_o};
    checks++;
    if (f !== 4'b0000) begin errors++; $display("FAIL fwd_reg0 got %b exp %b", f, 4'b0000); end
    reg_wr_mem_i = 1; dst_mem_i = 3; dst_wb_i = 4; rs_ex_i = 4; rt_ex_i = 3;
    #2; f = {fwd_a_sel_o, fwd_b_sel_o};
    checks++;
    if (f !== 4'b0110) begin errors++; $display("FAIL fwd_split got %b exp %b", f, 4'b0110); end
    step();
    clear_inputs();
  endtask

  task automatic test_div();
    logic [3:0] o;
    md_start_ex_i = 1; md_is_div_ex_i = 1;
    #2; o = {md_busy_o, stall_if_o, stall_id_o, md_done_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL div_start_cycle got %b exp %b", o, 4'b0000); end
    step();
    clear_inputs();
    for (int i = 0; i < 31; i++) begin
      if (i == 5) begin md_start_ex_i = 1; md_is_div_ex_i = 0; end
      if (i == 6) clear_inputs();
      if (i == 8) drive_load_use();
      if (i == 9) clear_inputs();
      #2; o = {md_busy_o, stall_if_o, stall_id_o, clr_ex_o};
      checks++;
      if (o !== 4'b1110) begin errors++; $display("FAIL div_busy[%0d] got %b exp %b", i, o, 4'b1110); end
      checks++;
      if (md_done_o !== (i == 30)) begin
        errors++; $display("FAIL div_done[%0d] got %b exp %b", i, md_done_o, (i == 30));
      end
      step();
    end
    #2; o = {md_busy_o, stall_if_o, stall_id_o, md_done_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL div_release got %b exp %b", o, 4'b0000); end
    step();
  endtask

  task automatic test_mul_abort();
    logic [5:0] o;
    md_start_ex_i = 1; md_is_div_ex_i = 0;
    step();
    clear_inputs();
    #2; o = {clr_id_o, clr_ex_o, stall_if_o, stall_id_o, md_busy_o, md_done_o};
    checks++;
    if (o !== 6'b001110) begin errors++; $display("FAIL mul_busy1 got %b exp %b", o, 6'b001110); end
    step();
    mispredict_ex_i = 1;
    #2; o = {clr_id_o, clr_ex_o, stall_if_o, stall_id_o, md_busy_o, md_done_o};
    checks++;
    if (o !== 6'b110010) begin errors++; $display("FAIL mul_mispredict got %b exp %b", o, 6'b110010); end
    step();
    mispredict_ex_i = 0;
    for (int i = 0; i < 2; i++) begin
      #2; o = {clr_id_o, clr_ex_o, stall_if_o, stall_id_o, md_busy_o, md_done_o};
      checks++;
      if (o !== 6'b110000) begin errors++; $display("FAIL mul_abort_flush[%0d] got %b exp %b", i, o, 6'b110000); end
      step();
    end
    #2; o = {clr_id_o, clr_ex_o, stall_if_o, stall_id_o, md_busy_o, md_done_o};
    checks++;
    if (o !== 6'b000000) begin errors++; $display("FAIL mul_abort_idle got %b exp %b", o, 6'b000000); end
    step();
  endtask

  task automatic test_flush_lu();
    logic [3:0] o;
    drive_load_use(); mispredict_ex_i = 1;
    for (int i = 0; i < 3; i++) begin
      #2; o = {clr_id_o, clr_ex_o, stall_if_o, stall_id_o};
      checks++;
      if (o !== 4'b1100) begin errors++; $display("FAIL flush_lu[%0d] got %b exp %b", i, o, 4'b1100); end
      step();
      mispredict_ex_i = 0;
    end
    clear_inputs();
    #2; o = {clr_id_o, clr_ex_o, stall_if_o, stall_id_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL flush_end got %b exp %b", o, 4'b0000); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] o;
    logic [2:0] m;
    md_start_ex_i = 1; md_is_div_ex_i = 0;
    drive_load_use();
    #2; o = {stall_if_o, stall_id_o, clr_ex_o, md_busy_o};
    checks++;
    if (o !== 4'b0000) begin errors++; $display("FAIL md_over_lu got %b exp %b", o, 4'b0000); end
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #2; m = {md_busy_o, stall_if_o, md_done_o};
      checks++;
      if (m !== {2'b11, (i == 2)}) begin
        errors++; $display("FAIL mul_run[%0d] got %b exp %b", i, m, {2'b11, (i == 2)});
      end
      step();
    end
    #2; m = {md_busy_o, stall_if_o, md_done_o};
    checks++;
    if (m !== 3'b000) begin errors++; $display("FAIL mul_release got %b exp %b", m, 3'b000); end
    step();
  endtask

  task automatic test_reset_mid_div();
    logic [9:0] all_out;
    logic [3:0] o;
    md_start_ex_i = 1; md_is_div_ex_i = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 10; i++) step();
    reg_wr_mem_i = 1; dst_mem_i = 6; rs_ex_i = 6; rt_ex_i = 6; mispredict_ex_i = 1;
    #1;
    reset_n = 0;
    #1;
    all_out = {stall_if_o, stall_id_o, clr_id_o, clr_ex_o, fwd_a_sel_o, fwd_b_sel_o, md_busy_o, md_done_o};
    checks++;
    if (all_out !== 10'b0) begin errors++; $display("FAIL async_reset got %b exp %b", all_out, 10'b0); end
    step();
    step();
    reset_n = 1;
    clear_inputs();
    #2; all_out = {stall_if_o, stall_id_o, clr_id_o, clr_ex_o, fwd_a_sel_o, fwd_b_sel_o, md_busy_o, md_done_o};
    checks++;
    if (all_out !== 10'b0) begin errors++; $display("FAIL post_reset got %b exp %b", all_out, 10'b0); end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if ({stall_cnt_o, flush_cnt_o} !== 64'd0) begin
      errors++; $display("FAIL perf_reset got %h exp %h", {stall_cnt_o, flush_cnt_o}, 64'd0);
    end
`endif
    drive_load_use();
    #1; o = {stall_if_o, stall_id_o, clr_ex_o, md_busy_o};
    checks++;
    if (o !== 4'b1110) begin errors++; $display("FAIL post_reset_idle got %b exp %b", o, 4'b1110); end
    step();
    clear_inputs();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf_cnt();
    // one stall cycle was counted at the end of test_reset_mid_div
    #2;
    checks++;
    if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL perf_stall got %0d exp %0d", stall_cnt_o, 1); end
    mispredict_ex_i = 1;
    step();
    mispredict_ex_i = 0;
    #2;
    checks++;
    if ({stall_cnt_o, flush_cnt_o} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL perf_flush got %h exp %h", {stall_cnt_o, flush_cnt_o}, {32'd1, 32'd1});
    end
    step(); step(); step();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_div();
    test_mul_abort();
    test_flush_lu();
    test_back_to_back();
    test_reset_mid_div();
`ifdef HAZ_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
